// File: rtl/line_fill_pkg.sv
// Shared types and constants for the line fill/writeback engine.
package line_fill_pkg;

    localparam int LINE_BITS     = 512;
    localparam int WORD_BITS     = 32;
    localparam int ADDR_BITS     = 32;
    localparam int LINE_BYTES    = LINE_BITS / 8;
    localparam int OFFSET_BITS   = 6;
    localparam int BEATS         = LINE_BITS / WORD_BITS;
    localparam int BEAT_IDX_BITS = 4;
    localparam int CNT_BITS      = 5;

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    // Byte address of word idx within the line at base; wraps modulo 2^ADDR_BITS.
    function automatic logic [ADDR_BITS-1:0] beat_addr(input logic [ADDR_BITS-1:0]     base,
                                                       input logic [BEAT_IDX_BITS-1:0] idx);
        return base + ADDR_BITS'({idx, 2'b00});
    endfunction

endpackage

// File: rtl/lfe_line_buffer.sv
// One cache line of storage: parallel load, indexed word write, indexed word read.
module lfe_line_buffer
    import line_fill_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [LINE_BITS-1:0]     load_line,
    input  logic                     wr_en,
    input  logic [BEAT_IDX_BITS-1:0] wr_idx,
    input  logic [WORD_BITS-1:0]     wr_word,
    input  logic [BEAT_IDX_BITS-1:0] rd_idx,
    output logic [WORD_BITS-1:0]     rd_word,
    output logic [LINE_BITS-1:0]     line
);

    logic [BEATS-1:0][WORD_BITS-1:0] words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            words <= '0;
        else if (load)
            words <= load_line;
        else if (wr_en)
            words[wr_idx] <= wr_word;
    end

    assign rd_word = words[rd_idx];
    assign line    = words;

endmodule

// File: rtl/line_fill_engine.sv
// Serialises cache line fills/writebacks into 32-bit memory beats.
// Define LINE_FILL_CWF_EN to issue fills critical-word-first.
module line_fill_engine
    import line_fill_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [LINE_BITS-1:0] resp_rdata,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    input  logic                 mem_rvalid,
    input  logic [WORD_BITS-1:0] mem_rdata
);

    state_t                   state, state_nxt;
    logic                     is_wr;
    logic [ADDR_BITS-1:0]     base;
    logic [BEAT_IDX_BITS-1:0] start, start_nxt, iss_idx, rcv_idx;
    logic [CNT_BITS-1:0]      iss, rcv;
    logic [LINE_BITS-1:0]     rdata_q, line;
    logic [WORD_BITS-1:0]     rd_word;
    logic                     accept, beat_hs, rx;
    logic                     unused_addr_bits;

    assign accept  = req_valid && req_ready;
    assign beat_hs = mem_valid && mem_ready;
    // Stray read data outside a fill is dropped; a fill leaves as the 16th word lands.
    assign rx      = (state == FILL) && mem_rvalid;
    assign iss_idx = start + iss[BEAT_IDX_BITS-1:0];
    assign rcv_idx = start + rcv[BEAT_IDX_BITS-1:0];
    assign unused_addr_bits = ^req_addr[OFFSET_BITS-1:0];

`ifdef LINE_FILL_CWF_EN
    assign start_nxt = req_write ? '0 : req_addr[OFFSET_BITS-1:2];
`else
    assign start_nxt = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_write ? WB : FILL;
            WB:      if (beat_hs && iss == CNT_BITS'(BEATS-1)) state_nxt = RESP;
            FILL:    if (rx && rcv == CNT_BITS'(BEATS-1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_rdata = rdata_q;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            WB: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = beat_addr(base, iss_idx);
                mem_wdata = rd_word;
            end
            FILL: begin
                mem_valid = (iss != CNT_BITS'(BEATS));
                mem_addr  = beat_addr(base, iss_idx);
            end
            // The final word is already in the buffer here; rdata_q keeps it afterwards.
            RESP:    if (!is_wr) resp_rdata = line;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr   <= 1'b0;
            base    <= '0;
            start   <= '0;
            iss     <= '0;
            rcv     <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                is_wr <= req_write;
                base  <= {req_addr[ADDR_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};
                start <= start_nxt;
                iss   <= '0;
                rcv   <= '0;
            end else begin
                if (beat_hs) iss <= iss + CNT_BITS'(1);
                if (rx)      rcv <= rcv + CNT_BITS'(1);
            end
            if (state == RESP && !is_wr)
                rdata_q <= line;
        end
    end

    lfe_line_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && req_write),
        .load_line (req_wdata),
        .wr_en     (rx),
        .wr_idx    (rcv_idx),
        .wr_word   (mem_rdata),
        .rd_idx    (iss_idx),
        .rd_word   (rd_word),
        .line      (line)
    );

endmodule

// File: tb/tb_line_fill_engine.sv
// Directed + randomized bench for line_fill_engine with a transaction-level memory model.
module tb_line_fill_engine;

`ifdef LINE_FILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0, req_write = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [511:0] req_wdata = '0;
    logic         req_ready, resp_valid, mem_valid, mem_we;
    logic [511:0] resp_rdata;
    logic [31:0]  mem_addr, mem_wdata;
    logic         mem_ready, mem_rvalid;
    logic [31:0]  mem_rdata;

    line_fill_engine dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus controls (written by the initial block only)
    int          ready_mode = 0, lat_min = 2, lat_max = 2, mem_pat = 0;
    bit          inject_stale = 1'b0;
    logic [31:0] mem_seed = 32'h1234_5678;

    // observations (written by the monitor only)
    typedef struct { int due; logic [31:0] data; } rd_t;
    rd_t          pend[$];
    logic [31:0]  hs_addr[$], hs_data[$];
    bit           hs_we[$];
    int           acc_cnt = 0, acc_cyc = 0, resp_cnt = 0, resp_cyc = 0, stall_bad = 0;
    int           last_due = 0, due;
    logic [511:0] resp_line = '0;
    bit           stall_prev = 1'b0;
    logic [31:0]  stall_addr, stall_data;

    int           checks = 0, errors = 0;
    logic [511:0] prev_line = '0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (mem_pat == 0) return 32'h100 + {28'd0, a[5:2]};
        return (a * 32'h9E37_79B1) ^ mem_seed;
    endfunction

    // Memory model: drive this cycle's inputs first, then observe handshakes with them.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            last_due   = 0;
            stall_prev = 1'b0;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end else begin
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = !mem_ready;
                default: mem_ready = ($urandom_range(3, 0) != 0);
            endcase
            if (inject_stale) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend[0].data;
                void'(pend.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
            if (req_valid && req_ready) begin acc_cnt++; acc_cyc = cyc; end
            if (resp_valid) begin resp_cnt++; resp_cyc = cyc; resp_line = resp_rdata; end
            if (stall_prev && (!mem_valid || mem_addr !== stall_addr || mem_wdata !== stall_data))
                stall_bad++;
            stall_prev = mem_valid && !mem_ready;
            stall_addr = mem_addr;
            stall_data = mem_wdata;
            if (mem_valid && mem_ready) begin
                hs_addr.push_back(mem_addr);
                hs_data.push_back(mem_wdata);
                hs_we.push_back(mem_we);
                if (!mem_we) begin
                    due = cyc + int'($urandom_range(lat_max, lat_min));
                    if (due < last_due) due = last_due;
                    last_due = due;
                    pend.push_back('{due, memfn(mem_addr)});
                end
            end
        end
    end

    task automatic chk_line(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk_w({tag, " req_ready"},  {31'd0, req_ready},  32'd1);
        chk_w({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk_w({tag, " mem_valid"},  {31'd0, mem_valid},  32'd0);
        chk_w({tag, " mem_we"},     {31'd0, mem_we},     32'd0);
        chk_w({tag, " mem_addr"},   mem_addr,            32'd0);
        chk_w({tag, " mem_wdata"},  mem_wdata,           32'd0);
        chk_line({tag, " resp_rdata"}, resp_rdata, '0);
    endtask

    // Expected beats and fill line for a request, straight from the line/word rules.
    task automatic expect_txn(input bit we, input logic [31:0] addr, input logic [511:0] wd,
                              input int h0, input string tag);
        int n, c, k;
        logic [31:0]  base;
        logic [511:0] exp_a, exp_d, obs_a, obs_d, exp_line;
        logic [15:0]  exp_w, obs_w;
        base = addr & ~32'h3F;
        c = (!we && CWF) ? int'(addr[5:2]) : 0;
        exp_a = '0; exp_d = '0; obs_a = '0; obs_d = '0; exp_w = '0; obs_w = '0;
        n = hs_addr.size() - h0;
        chk_i({tag, " beats"}, n, 16);
        for (int j = 0; j < 16; j++) begin
            k = (c + j) % 16;
            exp_a[32*j +: 32] = base + 32'(4 * k);
            exp_d[32*j +: 32] = we ? wd[32*k +: 32] : 32'h0;
            exp_w[j] = we;
            if (j < n) begin
                obs_a[32*j +: 32] = hs_addr[h0+j];
                obs_d[32*j +: 32] = hs_we[h0+j] ? hs_data[h0+j] : 32'h0;
                obs_w[j] = hs_we[h0+j];
            end
        end
        chk_line({tag, " beat addrs"}, obs_a, exp_a);
        chk_w({tag, " beat we"}, {16'd0, obs_w}, {16'd0, exp_w});
        if (we) chk_line({tag, " beat data"}, obs_d, exp_d);
        if (we) exp_line = prev_line;
        else for (int w = 0; w < 16; w++) exp_line[32*w +: 32] = memfn(base + 32'(4 * w));
        chk_line({tag, " resp_rdata"}, resp_line, exp_line);
        if (!we) prev_line = exp_line;
    endtask

    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [511:0] wd,
                           input int exp_lat, input string tag);
        int h0, r0, a0, sb0, n, my_acc;
        h0 = hs_addr.size(); r0 = resp_cnt; a0 = acc_cnt; sb0 = stall_bad;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = we; req_addr = addr; req_wdata = wd;
        n = 0;
        while (acc_cnt == a0 && n < 50) begin @(posedge clk); n++; end
        chk_i({tag, " accepted"}, acc_cnt - a0, 1);
        my_acc = acc_cyc;
        #1 req_valid = 1'b0;
        n = 0;
        while (resp_cnt == r0 && n < 600) begin @(posedge clk); n++; end
        repeat (3) @(posedge clk);
        chk_i({tag, " resp pulses"}, resp_cnt - r0, 1);
        expect_txn(we, addr, wd, h0, tag);
        if (exp_lat > 0) chk_i({tag, " latency"}, resp_cyc - my_acc, exp_lat);
        chk_i({tag, " stall stable"}, stall_bad - sb0, 0);
    endtask

    logic [511:0] wd;
    int h0, r0, a0, n, lat;

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_reset("reset");
        rst_n = 1'b1;

        // fill, returned word = 0x100+k, 2-cycle latency, no stalls
        run_txn(1'b0, 32'h0001_0040, '0, 19, "fill40");

        // writeback with word k = k and a toggling mem_ready
        for (int k = 0; k < 16; k++) wd[32*k +: 32] = 32'(k);
        ready_mode = 1;
        run_txn(1'b1, 32'h0002_0000, wd, 0, "wb_toggle");

        // unaligned fill address: base-aligned without CWF, word-15-first with it
        ready_mode = 0;
        run_txn(1'b0, 32'h0001_007C, '0, 19, "fill7c");
        run_txn(1'b0, 32'h0000_0028, '0, 19, "fill28");

        // reset in the middle of a fill
        h0 = hs_addr.size();
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0003_0000;
        n = 0;
        while (hs_addr.size() - h0 < 5 && n < 50) begin @(posedge clk); n++; end
        chk_i("midfill beats before reset", (hs_addr.size() - h0 >= 5) ? 1 : 0, 1);
        #3 rst_n = 1'b0; req_valid = 1'b0;
        #1 chk_reset("midfill reset");
        prev_line = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk_w("post reset req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1 inject_stale = 1'b1;
        @(posedge clk); #1 inject_stale = 1'b0;
        run_txn(1'b0, 32'h0000_0080, '0, 19, "fill80");

        // unstalled writeback latency
        for (int k = 0; k < 16; k++) wd[32*k +: 32] = $urandom;
        run_txn(1'b1, 32'hFFFF_FFC4, wd, 17, "wb_top");

        // req_valid held high: writeback then fill, one IDLE cycle between them
        for (int k = 0; k < 16; k++) wd[32*k +: 32] = $urandom;
        h0 = hs_addr.size(); r0 = resp_cnt; a0 = acc_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0004_0000; req_wdata = wd;
        n = 0;
        while (acc_cnt == a0 && n < 50) begin @(posedge clk); n++; end
        #1 req_write = 1'b0; req_addr = 32'h0005_0044;
        n = 0;
        while (acc_cnt < a0 + 2 && n < 100) begin @(posedge clk); n++; end
        chk_i("held second accept", acc_cnt - a0, 2);
        chk_i("held resp before 2nd accept", resp_cnt - r0, 1);
        chk_i("held accept gap", acc_cyc - resp_cyc, 1);
        chk_i("held wb beats", hs_addr.size() - h0, 16);
        expect_txn(1'b1, 32'h0004_0000, wd, h0, "held_wb");
        #1 req_valid = 1'b0;
        h0 = hs_addr.size();
        n = 0;
        while (resp_cnt < r0 + 2 && n < 100) begin @(posedge clk); n++; end
        repeat (3) @(posedge clk);
        chk_i("held resp pulses", resp_cnt - r0, 2);
        expect_txn(1'b0, 32'h0005_0044, '0, h0, "held_fill");

        // randomized traffic against the model
        mem_pat = 1;
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < 16; k++) wd[32*k +: 32] = $urandom;
            ready_mode = int'($urandom_range(2, 0));
            lat_max = int'($urandom_range(4, 1));
            lat_min = ($urandom_range(1, 0) != 0) ? lat_max : 1;
            mem_seed = $urandom;
            lat = 0;
            if (ready_mode == 0 && lat_min == lat_max) lat = 17;
            if ($urandom_range(1, 0) != 0) begin
                run_txn(1'b1, $urandom, wd, lat, $sformatf("rnd%0d_wb", t));
            end else begin
                if (lat != 0) lat = 16 + lat_max + 1;
                run_txn(1'b0, $urandom, '0, lat, $sformatf("rnd%0d_fill", t));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
